load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 31 +++
 rtl/load_store_unit_if.sv | 22 ++
 rtl/load_store_unit_load_extend.sv | 49 ++++
 rtl/load_store_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes, FSM states
// and the access-size decode.
package load_store_unit_pkg;

    localparam logic [2:0] Funct3B    = 3'b000;
    localparam logic [2:0] Funct3H    = 3'b001;
    localparam logic [2:0] Funct3W    = 3'b010;
    localparam logic [2:0] Funct3D    = 3'b011;
    localparam logic [2:0] Funct3Bu   = 3'b100;
    localparam logic [2:0] Funct3Hu   = 3'b101;
    localparam logic [2:0] Funct3Wu   = 3'b110;
    localparam logic [2:0] Funct3Rsvd = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDone = 2'd2,
        StErr  = 2'd3
    } lsu_state_e;

    // Size in bytes depends only on the low two funct3 bits.
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'd0:    return 4'd1;
            2'd1:    return 4'd2;
            2'd2:    return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Memory-side bus of the load/store unit: one outstanding request, acked by the memory.
interface load_store_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [XLEN-1:0]       mem_addr;
    logic [XLEN/8-1:0]     mem_be;
    logic [XLEN-1:0]       mem_wdata;
    logic                  mem_ack;
    logic [XLEN-1:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/load_store_unit_load_extend.sv
// Picks the addressed lanes out of a full memory word and sign/zero-extends them.
module load_extend
    import load_store_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]                  funct3_i,
    input  logic [$clog2(XLEN/8)-1:0]   offset_i,
    input  logic [XLEN-1:0]             word_i,
    output logic [XLEN-1:0]             data_o
);

    logic [XLEN-1:0] shifted;

    assign shifted = word_i >> {offset_i, 3'b000};

    always_comb begin
        data_o = shifted;
        unique case (funct3_i)
            Funct3B: begin
                data_o      = {XLEN{shifted[7]}};
                data_o[7:0] = shifted[7:0];
            end
            Funct3H: begin
                data_o       = {XLEN{shifted[15]}};
                data_o[15:0] = shifted[15:0];
            end
            Funct3W: begin
                data_o       = {XLEN{shifted[31]}};
                data_o[31:0] = shifted[31:0];
            end
            Funct3D: data_o = shifted;
            Funct3Bu: begin
                data_o      = '0;
                data_o[7:0] = shifted[7:0];
            end
            Funct3Hu: begin
                data_o       = '0;
                data_o[15:0] = shifted[15:0];
            end
            Funct3Wu: begin
                data_o       = '0;
                data_o[31:0] = shifted[31:0];
            end
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: validates the access, issues one memory
// request with a bounded wait, and returns the extended load result.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               is_store,
    input  logic [2:0]         funct3,
    input  logic [XLEN-1:0]    addr,
    input  logic [XLEN-1:0]    wdata,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [XLEN-1:0]    rdata,
    load_store_unit_if.master  mem
);

    localparam int unsigned NumBytes = XLEN / 8;
    localparam int unsigned OffW     = $clog2(NumBytes);
    localparam int unsigned CntW     = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    lsu_state_e        state_q, state_d;
    logic              is_store_q, is_store_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;

    logic [3:0]          in_size;
    logic [OffW-1:0]     in_mask;
    logic                in_illegal;
    logic                in_misaligned;
    logic [3:0]          size_q;
    logic [NumBytes-1:0] be_base;
    logic [XLEN-1:0]     wdata_rep;
    logic [XLEN-1:0]     load_data;

    // Legality is judged on the request inputs in the same cycle they are latched.
    always_comb begin
        in_size       = size_bytes(funct3);
        in_mask       = OffW'(in_size - 4'd1);
        in_illegal    = (funct3 == Funct3Rsvd) || (is_store && funct3[2]) ||
                        ((XLEN == 32) && ((funct3 == Funct3D) || (funct3 == Funct3Wu)));
        in_misaligned = |(addr[OffW-1:0] & in_mask);
    end

    always_comb begin
        size_q = size_bytes(funct3_q);
        for (int i = 0; i < NumBytes; i++) begin
            be_base[i]         = (i < int'(size_q));
            wdata_rep[8*i +: 8] = wdata_q[8*(i & (int'(size_q) - 1)) +: 8];
        end
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = {addr_q[XLEN-1:OffW], {OffW{1'b0}}};
    assign mem.mem_be    = mem_req_q ? (be_base << addr_q[OffW-1:0]) : '0;
    assign mem.mem_wdata = wdata_rep;

    load_extend #(
        .XLEN (XLEN)
    ) u_load_extend (
        .funct3_i (funct3_q),
        .offset_i (addr_q[OffW-1:0]),
        .word_i   (mem.mem_rdata),
        .data_o   (load_data)
    );

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    is_store_d = is_store;
                    funct3_d   = funct3;
                    addr_d     = addr;
                    wdata_d    = wdata;
                    if (in_illegal || in_misaligned) begin
                        state_d = StErr;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d   = StReq;
                        cnt_d     = '0;
                        mem_req_d = 1'b1;
                        mem_we_d  = is_store;
                    end
                end
            end
            StReq: begin
                // An ack in the final wait cycle still completes the access.
                if (mem.mem_ack) begin
                    state_d   = StDone;
                    done_d    = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (!is_store_q) begin
                        rdata_d = load_data;
                    end
                end else if (cnt_q == CntLast) begin
                    state_d   = StErr;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            is_store_q <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;
    assign rdata = rdata_q;

endmodule
